// File: rtl/ysyx_040750_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040750_muldiv_ctrl
// Brief    : EX-stage iterative multiply/divide sequencer (shift-add multiplier,
//            restoring divider) with valid/allowout result handshake.
//            Optional macro YSYX_040750_MULDIV_EARLY_OUT_EN: MUL stops as soon
//            as the remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_040750_muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            I_sys_clk,
    input  logic            I_rst_n,
    input  logic            I_start,
    input  logic [4:0]      I_op_sel,
    input  logic            I_word_op,
    input  logic [XLEN-1:0] I_src1,
    input  logic [XLEN-1:0] I_src2,
    input  logic            I_flush,
    input  logic            I_allowout,
    output logic            O_ready,
    output logic            O_busy,
    output logic            O_valid,
    output logic [XLEN-1:0] O_result
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    function automatic logic [XLEN-1:0] f_sext_word(input logic [XLEN-1:0] v);
        return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic            r_is_mul;
    logic            r_is_rem;
    logic            r_word;
    logic            r_quo_neg;
    logic            r_rem_neg;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;
    logic [XLEN-1:0] r_result;

    // ---------------- operand preparation ----------------
    logic            w_is_mul;
    logic            w_is_signed;
    logic            w_is_rem;
    logic            w_zext;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN-1:0] w_mplier;
    logic [XLEN-1:0] w_dividend_init;
    logic [XLEN-1:0] w_min_neg;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_mul_zero;
    logic            w_special;
    logic [XLEN-1:0] w_special_raw;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept;

    assign w_is_mul    = I_op_sel[0];
    assign w_is_signed = I_op_sel[1] | I_op_sel[3];
    assign w_is_rem    = I_op_sel[3] | I_op_sel[4];
    assign w_zext      = I_op_sel[2] | I_op_sel[4];

    assign w_a = I_word_op ? (w_zext ? {{HALF{1'b0}}, I_src1[HALF-1:0]} : f_sext_word(I_src1)) : I_src1;
    assign w_b = I_word_op ? (w_zext ? {{HALF{1'b0}}, I_src2[HALF-1:0]} : f_sext_word(I_src2)) : I_src2;

    assign w_neg_a = w_is_signed & w_a[XLEN-1];
    assign w_neg_b = w_is_signed & w_b[XLEN-1];
    assign w_mag_a = w_neg_a ? -w_a : w_a;
    assign w_mag_b = w_neg_b ? -w_b : w_b;

    // Zero-extended word multiplier lets the early-out test see only live bits.
    assign w_mplier = I_word_op ? {{HALF{1'b0}}, I_src2[HALF-1:0]} : I_src2;

    // Word dividends are pre-shifted so N iterations consume exactly their bits.
    assign w_dividend_init = I_word_op ? {w_mag_a[HALF-1:0], {HALF{1'b0}}} : w_mag_a;

    assign w_min_neg  = I_word_op ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                  : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = ~w_is_mul & (w_b == '0);
    assign w_ovf      = w_is_signed & (w_a == w_min_neg) & (w_b == '1);

`ifdef YSYX_040750_MULDIV_EARLY_OUT_EN
    assign w_mul_zero = w_is_mul & (w_mplier == '0);
`else
    assign w_mul_zero = 1'b0;
`endif

    assign w_special = w_div_zero | w_ovf | w_mul_zero;

    always_comb begin
        w_special_raw = '0;
        if (w_div_zero) begin
            w_special_raw = w_is_rem ? w_a : '1;
        end else if (w_ovf) begin
            w_special_raw = w_is_rem ? '0 : w_a;
        end
    end

    assign w_special_res = I_word_op ? f_sext_word(w_special_raw) : w_special_raw;
    assign w_accept      = (r_state == c_idle) & I_start & ~I_flush;

    // ---------------- iteration datapath ----------------
    logic [XLEN-1:0] w_mul_acc;
    logic [XLEN-1:0] w_mul_x;
    logic [XLEN-1:0] w_mul_y;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_div_acc;
    logic [XLEN-1:0] w_div_y;
    logic [XLEN-1:0] w_div_res;
    logic [XLEN-1:0] w_calc_raw;
    logic [XLEN-1:0] w_calc_res;
    logic            w_cnt_last;
    logic            w_last;

    assign w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;
    assign w_mul_x   = r_x << 1;
    assign w_mul_y   = r_y >> 1;

    // Remainder after restore is always below the divisor, so the low XLEN
    // bits of the difference are exact.
    assign w_rem_sh  = {r_acc, r_y[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_x});
    assign w_div_acc = w_ge ? (w_rem_sh[XLEN-1:0] - r_x) : w_rem_sh[XLEN-1:0];
    assign w_div_y   = {r_y[XLEN-2:0], w_ge};

    assign w_div_res = r_is_rem ? (r_rem_neg ? -w_div_acc : w_div_acc)
                                : (r_quo_neg ? -w_div_y   : w_div_y);
    assign w_calc_raw = r_is_mul ? w_mul_acc : w_div_res;
    assign w_calc_res = r_word ? f_sext_word(w_calc_raw) : w_calc_raw;

    assign w_cnt_last = (r_cnt == (r_word ? CW'(HALF-1) : CW'(XLEN-1)));

`ifdef YSYX_040750_MULDIV_EARLY_OUT_EN
    assign w_last = w_cnt_last | (r_is_mul & (w_mul_y == '0));
`else
    assign w_last = w_cnt_last;
`endif

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_is_mul  <= 1'b0;
            r_is_rem  <= 1'b0;
            r_word    <= 1'b0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_is_mul  <= w_is_mul;
            r_is_rem  <= w_is_rem;
            r_word    <= I_word_op;
            r_quo_neg <= w_neg_a ^ w_neg_b;
            r_rem_neg <= w_neg_a;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_x       <= w_is_mul ? w_a : w_mag_b;
            r_y       <= w_is_mul ? w_mplier : w_dividend_init;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == c_calc) && !I_flush) begin
            r_acc <= r_is_mul ? w_mul_acc : w_div_acc;
            r_x   <= r_is_mul ? w_mul_x : r_x;
            r_y   <= r_is_mul ? w_mul_y : w_div_y;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_calc_res;
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? c_done : c_calc;
                end
            end
            c_calc: begin
                if (I_flush) begin
                    w_state_nxt = c_idle;
                end else if (w_last) begin
                    w_state_nxt = c_done;
                end
            end
            c_done: begin
                if (I_flush || I_allowout) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        O_ready  = (r_state == c_idle);
        O_busy   = (r_state == c_calc);
        O_valid  = (r_state == c_done);
        O_result = r_result;
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_040750_muldiv_ctrl.sv
`default_nettype none
// Randomized scoreboard bench for ysyx_040750_muldiv_ctrl; reference model uses
// plain RV64 M-extension arithmetic.
module tb_ysyx_040750_muldiv_ctrl;

    localparam logic [4:0] OP_MUL  = 5'b00001;
    localparam logic [4:0] OP_DIV  = 5'b00010;
    localparam logic [4:0] OP_DIVU = 5'b00100;
    localparam logic [4:0] OP_REM  = 5'b01000;
    localparam logic [4:0] OP_REMU = 5'b10000;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  op_sel;
    logic        word_op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        allowout;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [63:0] result;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          rand_ao = 1'b0;
    exp_t        scb[$];
    exp_t        cur;
    bit          seen = 1'b0;
    logic [63:0] last_res = '0;

    ysyx_040750_muldiv_ctrl #(.XLEN(64)) dut (
        .I_sys_clk (clk),
        .I_rst_n   (rst_n),
        .I_start   (start),
        .I_op_sel  (op_sel),
        .I_word_op (word_op),
        .I_src1    (src1),
        .I_src2    (src2),
        .I_flush   (flush),
        .I_allowout(allowout),
        .O_ready   (ready),
        .O_busy    (busy),
        .O_valid   (valid),
        .O_result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [4:0] op, input bit word,
                                            input logic [63:0] a, input logic [63:0] b);
        longint      sa, sb, smin;
        logic [63:0] ua, ub, r;
        int          ia, ib;
        ia = int'(a[31:0]);
        ib = int'(b[31:0]);
        if (word) begin
            sa = longint'(ia); sb = longint'(ib);
            ua = {32'd0, a[31:0]}; ub = {32'd0, b[31:0]};
            smin = -(longint'(1) <<< 31);
        end else begin
            sa = longint'(a); sb = longint'(b);
            ua = a; ub = b;
            smin = longint'(1) <<< 63;
        end
        r = '0;
        case (op)
            OP_MUL:  r = ua * ub;
            OP_DIV:  if (sb == 0) r = '1;
                     else if (sa == smin && sb == -1) r = sa;
                     else r = sa / sb;
            OP_DIVU: r = (ub == 0) ? '1 : ua / ub;
            OP_REM:  if (sb == 0) r = sa;
                     else if (sa == smin && sb == -1) r = '0;
                     else r = sa % sb;
            OP_REMU: r = (ub == 0) ? ua : ua % ub;
            default: r = '0;
        endcase
        if (word) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input bit word,
                                   input logic [63:0] a, input logic [63:0] b);
        int          n;
        logic [63:0] m;
        longint      sa, sb, smin;
        int          ia, ib;
        n  = word ? 32 : 64;
        m  = word ? {32'd0, b[31:0]} : b;
        ia = int'(a[31:0]);
        ib = int'(b[31:0]);
        sa = word ? longint'(ia) : longint'(a);
        sb = word ? longint'(ib) : longint'(b);
        smin = word ? -(longint'(1) <<< 31) : (longint'(1) <<< 63);
        if (op == OP_MUL) begin
`ifdef YSYX_040750_MULDIV_EARLY_OUT_EN
            int msb;
            msb = -1;
            for (int i = 0; i < 64; i++) if (m[i]) msb = i;
            return (msb < 0) ? 1 : msb + 2;
`else
            return n + 1;
`endif
        end
        if (m == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && sa == smin && sb == -1) return 1;
        return n + 1;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return 64'hFFFF_FFFF_8000_0000;
            5:       return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ao) allowout = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [4:0] op, input bit word, input logic [63:0] a,
                         input logic [63:0] b, input bit push);
        int n;
        n = 0;
        while (!ready && n < 300) begin tick(); n++; end
        if (!ready) begin
            total++; bad++;
            $display("FAIL issue_timeout: ready=%b required 1", ready);
        end else begin
            op_sel = op; word_op = word; src1 = a; src2 = b; start = 1'b1;
            if (push) scb.push_back('{ref_res(op, word, a, b), cyc, ref_lat(op, word, a, b)});
            tick();
            start = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!valid && n < 200) begin tick(); n++; end
        if (!valid) begin
            total++; bad++;
            $display("FAIL valid_timeout: valid=%b required 1", valid);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (scb.size() != 0 && n < 400) begin tick(); n++; end
    endtask

    // Monitor: pops one expectation when a result first appears, then checks it holds.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (scb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: result %h, none required", result);
                    cur.res = result; cur.acc = cyc; cur.lat = 0;
                end else begin
                    cur = scb.pop_front();
                    last_res = cur.res;
                    chk("result", result, cur.res);
                    chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                end
            end else begin
                chk("result_hold", result, cur.res);
            end
            if (allowout || flush) seen = 1'b0;
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [4:0]  d_op [7] = '{OP_MUL, OP_DIV, OP_REM, OP_REMU, OP_DIV, OP_DIVU, OP_MUL};
    bit          d_w  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] d_a  [7] = '{64'd3, -64'd7, -64'd7, 64'd7, 64'h8000_0000, 64'd12345, 64'h1_0000};
    logic [63:0] d_b  [7] = '{64'd5, 64'd2, 64'd2, 64'd0, 64'hFFFF_FFFF, 64'd0, 64'h1_0000};

    initial begin
        logic [63:0] lr;
        rst_n = 1'b0; start = 1'b0; op_sel = OP_MUL; word_op = 1'b0;
        src1 = '0; src2 = '0; flush = 1'b0; allowout = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        rst_n = 1'b1;
        allowout = 1'b1;
        tick();

        // Directed cases, each followed by the one-cycle idle bubble check.
        for (int i = 0; i < 7; i++) begin
            issue(d_op[i], d_w[i], d_a[i], d_b[i], 1'b1);
            wait_valid();
            tick();
            chk("idle_after_handshake", 64'(ready), 64'd1);
            chk("valid_after_handshake", 64'(valid), 64'd0);
        end

        rand_ao = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(5'd1 << $urandom_range(0, 4), 1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
        end
        rand_ao = 1'b0;
        allowout = 1'b1;
        drain();

        // Result held in DONE; a start pulse there must be ignored.
        allowout = 1'b0;
        issue(OP_MUL, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                op_sel = OP_DIV; word_op = 1'b0; src1 = 64'd100; src2 = 64'd0; start = 1'b1;
            end
            tick();
            start = 1'b0;
            chk("hold_valid", 64'(valid), 64'd1);
            chk("hold_busy", 64'(busy), 64'd0);
        end
        allowout = 1'b1;
        tick();
        chk("release_ready", 64'(ready), 64'd1);
        issue(OP_DIVU, 1'b0, {$urandom, $urandom}, 64'd7, 1'b1);
        wait_valid();
        tick();

        // Flush wins over start in IDLE.
        op_sel = OP_DIV; src1 = 64'd9; src2 = 64'd3; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_over_start", 64'(ready), 64'd1);

        // Flush during CALC cycle 20.
        lr = last_res;
        issue(OP_DIV, 1'b0, {$urandom, $urandom}, 64'd3, 1'b0);
        repeat (19) tick();
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", 64'(ready), 64'd1);
        chk("flush_valid", 64'(valid), 64'd0);
        chk("flush_result_kept", result, lr);
        repeat (80) tick();

        // Asynchronous reset during CALC.
        issue(OP_MUL, 1'b0, {$urandom, $urandom}, {$urandom, $urandom} | 64'd1, 1'b0);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_ready", 64'(ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_result", result, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(OP_REMU, 1'b1, {$urandom, $urandom}, 64'd13, 1'b1);
        drain();
        chk("queue_empty", 64'(scb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_040750_muldiv_ctrl.md
# ysyx_040750_muldiv_ctrl

Iterative multiply/divide sequencer for the EX stage. It accepts one multicycle ALU operation when the ID/EX register launches one. It iterates a shift-add multiplier or a restoring divider. It holds the result with a valid/allowout handshake, and its valid output drives the ID/EX register's ALU-output-valid input so the register stalls until the result is consumed.

## Interface
Parameters:
- XLEN, 64, operand/result width (only 64 supported).

Ports:
- I_sys_clk  in  1  clock, all state on rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_start  in  1  launch pulse (ID/EX multicycle flag); sampled only in IDLE.
- I_op_sel  in  5  one-hot {REMU,REM,DIVU,DIV,MUL} = bits [4:0].
- I_word_op  in  1  RV64 *W variant: 32-bit operation, result sign-extended from bit 31.
- I_src1  in  XLEN  multiplicand / dividend.
- I_src2  in  XLEN  multiplier / divisor.
- I_flush  in  1  abort current operation.
- I_allowout  in  1  downstream accepts result.
- O_ready  out  1  state==IDLE.
- O_busy  out  1  state==CALC.
- O_valid  out  1  result valid (state==DONE).
- O_result  out  XLEN  result, registered, stable while O_valid.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE. Reset values: O_result=0, O_valid=0, O_busy=0, O_ready=1, counter=0.
- Operand prep on accept: word ops take low 32 bits, sign-extended for MUL/DIV/REM and zero-extended for DIVU/REMU. N = 32 for word ops, 64 otherwise. Signed divide works on magnitudes.
- Accept with I_start=1 in IDLE:
  - Divisor==0 → DONE directly. Quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM, dividend = most negative N-bit value, divisor = -1) → DONE directly. Quotient = dividend; remainder = 0.
  - Otherwise → CALC, counter=0.
- CALC MUL: if multiplier bit0 is 1, add multiplicand to the accumulator. Shift the multiplicand left and the multiplier right. Result is the low N bits of the accumulator.
- CALC DIV: shift the remainder:quotient pair left. Trial-subtract the divisor. If nonnegative, keep the difference and set the quotient bit.
- Leave CALC after iteration N (counter==N-1) → DONE, registering the final result.
  - Signed divide: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Word ops: sign-extend bit 31 of the result.
- DONE: O_valid=1. When I_allowout=1 → IDLE.
- I_flush=1 in any state → IDLE at the next edge and O_valid drops. Flush has priority over I_start and I_allowout. O_result keeps its old value.
- I_start outside IDLE is ignored (no queueing).
- Asynchronous reset mid-CALC or mid-DONE → IDLE immediately; the result is discarded.

## Timing
- Accept edge = cycle 0.
- Normal op: CALC occupies cycles 1..N; O_valid first high in cycle N+1 (cycle 65 for 64-bit, 33 for word).
- Special-case divide: O_valid high in cycle 1.
- Back-to-back: DONE+allowout at edge k → IDLE in cycle k+1. The next I_start is accepted at edge k+1. This gives one idle bubble minimum.
- O_valid and O_result hold indefinitely while I_allowout=0.

## Configuration
- YSYX_040750_MULDIV_EARLY_OUT_EN defined: MUL leaves CALC as soon as the shifted multiplier register becomes zero. If the multiplier is zero at accept, MUL goes straight to DONE with result 0 (valid in cycle 1). Divide latency is unchanged.
- Undefined: MUL always takes the full N iterations.

## Test plan
- MUL src1=3, src2=5, 64-bit → O_result=15. O_valid at cycle 65, or at cycle 4 with the early-out macro defined.
- DIV src1=-7, src2=2 → quotient -3. REM with the same operands → -1. REMU src1=7, src2=0 → 7 at cycle 1.
- DIVW src1=0x80000000, src2=0xFFFFFFFF → O_result=0xFFFFFFFF80000000 at cycle 1. DIVU src2=0 → all ones.
- MULW src1=0x10000, src2=0x10000 → O_result=0 (low 32 bits truncated). O_valid at cycle 33 without the early-out macro.
- Hold I_allowout=0 for 10 cycles in DONE → O_valid and O_result stable. Pulse I_start during this window → ignored. Then allowout → IDLE, and the next start is accepted one cycle later.
- I_flush in CALC cycle 20 → IDLE next cycle with no O_valid. Assert I_rst_n low mid-CALC → O_valid=0 and O_ready=1 immediately.
